regfile_issue: RTL
==================

# regfile_issue

Operand-issue stage directly upstream of the 32-bit ALU. It holds the 32×32 register file and reads two source registers per decoded instruction. It applies write-back bypass and a pending-write scoreboard, then presents registered `in1`/`in2`/`op`/`bi` to the ALU through a valid/ready handshake. ALU results return on the write-back port.

## Interface
**Parameters**
- `DW`, default 32: data width; matches ALU operand width.
- `AW`, default 5: register address width.
- `NREG`, default 32: register count, 2**AW; register 0 reads as zero.

**Ports**
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `dec_valid`, in, 1: decoded instruction present.
- `dec_ready`, out, 1: stage accepts the instruction this cycle.
- `dec_rs1` / `dec_rs2`, in, AW: source register addresses.
- `dec_rd`, in, AW: destination register address.
- `dec_op`, in, 2: ALU op (00 AND, 01 OR, 10 ADD/SUB, 11 zero).
- `dec_bi`, in, 1: invert-B / carry-in (1 = subtract).
- `alu_valid`, out, 1: issue register holds a valid operation.
- `alu_ready`, in, 1: ALU consumes the operation this cycle.
- `alu_in1` / `alu_in2`, out, DW: registered operands.
- `alu_op`, out, 2: registered op.
- `alu_bi`, out, 1: registered bi.
- `alu_rd`, out, AW: destination tag carried with the operation.
- `wb_en`, in, 1: write-back strobe.
- `wb_addr`, in, AW: write-back register address.
- `wb_data`, in, DW: write-back data.

## Operation
- **Storage.** Each register `i` ≠ 0 is written on a clock edge when `wb_en` is high and `wb_addr == i`. Writes to register 0 are dropped. Reads of register 0 always return 0.
- **Bypass.**
  - For each source `rsN` ≠ 0: if `wb_en` is high and `wb_addr == rsN` in the same cycle, the operand is `wb_data`.
  - Otherwise the operand is the stored value.
- **Scoreboard.** One `pending[NREG]` bit per register.
  - Set `pending[dec_rd]` on the accept edge when `dec_rd` ≠ 0.
  - Clear `pending[wb_addr]` on an edge where `wb_en` is high.
  - If set and clear target the same register on the same edge, set wins.
  - `pending[0]` is always 0.
- **Hazard.** `src_hz(r) = pending[r] && !(wb_en && wb_addr == r)`. The hazard signal is `hazard = src_hz(dec_rs1) | src_hz(dec_rs2) | src_hz(dec_rd)`, which covers RAW on both sources plus WAW on the destination.
- **Handshake.**
  - `dec_ready = (!alu_valid || alu_ready) && !hazard`. This is combinational and may depend on the `dec_*` fields.
  - Accept occurs when `dec_valid && dec_ready`.
- **Issue register states.**
  - EMPTY: `alu_valid` = 0.
  - FULL: `alu_valid` = 1.
- **Transitions.**
  - EMPTY → FULL on accept.
  - FULL → FULL on accept with `alu_ready` (back-to-back).
  - FULL → EMPTY on `alu_ready` with no accept.
  - FULL holds when `!alu_ready`.
- While FULL and `!alu_ready`, all `alu_*` outputs are stable. They are still updated by bypass? No: operands are captured at accept and never change afterward.
- A write-back to a register already captured in the issue register does not alter the issued operand.

## Timing
- **Reset.** Asynchronous assertion clears the following:
  - all registers to 0;
  - all `pending` bits;
  - `alu_valid`;
  - `alu_in1`, `alu_in2`, `alu_op`, `alu_bi` and `alu_rd` to 0.
- **Reset mid-operation.** An in-flight operation is discarded, and pending bits are lost. Write-backs still in flight after reset are applied to the file as ordinary writes.
- **Latency.** Accept at edge N gives `alu_valid` = 1 with operands valid after edge N. Sustained throughput is one operation per cycle with no hazards.
- **Write-back visibility.** Data written at edge N reads from the array from cycle N+1 onward. In cycle N itself it is visible through the bypass.
- `dec_ready` has no registered dependence on `dec_valid`. No combinational path runs from `alu_ready` to `alu_*` data.

## Structure
- **Package `alu_pkg`:**
  - `DW`, `AW`, `NREG`;
  - op encodings `OP_AND`=2'b00, `OP_OR`=2'b01, `OP_ADD`=2'b10, `OP_ZERO`=2'b11.
- **Sub-module `regfile_2r1w`:** storage array, register-0 forcing and the write-back bypass muxes.
- **Top level:** scoreboard, hazard logic and the issue register.

## Test plan
- **Basic issue.**
  - Stimulus: reset, then write-back r1=0x5 and r2=0x2. Issue rs1=1, rs2=2, rd=3, op=10, bi=1, with `alu_ready`=1.
  - Response: the next cycle shows `alu_valid`=1, `alu_in1`=0x5, `alu_in2`=0x2, `alu_bi`=1, `alu_rd`=3.
- **Register 0.**
  - Stimulus: write-back r0=0xFFFFFFFF, then issue rs1=0.
  - Response: `alu_in1`=0, and `pending[0]` never sets.
- **RAW stall and bypass.**
  - Stimulus: issue rd=4. Next, issue rs1=4 with no write-back.
  - Response: `dec_ready`=0.
  - Stimulus: apply `wb_en`=1, `wb_addr`=4, `wb_data`=0xA5A5A5A5 in the stall cycle.
  - Response: accepted in that cycle with `alu_in1`=0xA5A5A5A5.
- **Backpressure.**
  - Stimulus: `alu_ready`=0 while FULL. Change `dec_*` and write back to the captured source register.
  - Response: `alu_*` holds for 3 cycles, then drains on `alu_ready`=1.
- **Simultaneous set/clear.**
  - Stimulus: pending r7 receives write-back on the same edge that an instruction with rd=7 is accepted.
  - Response: `pending[7]` stays 1.
- **Reset mid-operation.**
  - Stimulus: assert `reset` while FULL with pending r5, asynchronously between edges.
  - Response: `alu_valid`=0 immediately, and an issue with rs1=5 is then accepted without stall.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and encodings for the operand-issue stage and the ALU it feeds.
package alu_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_ADD  = 2'b10,
    OP_ZERO = 2'b11
  } alu_op_e;

  typedef enum logic {
    ISS_EMPTY = 1'b0,
    ISS_FULL  = 1'b1
  } iss_state_e;

endpackage

// File: rtl/regfile_issue_if.sv
// Decode-side, ALU-side and write-back signals of the operand-issue stage.
interface regfile_issue_if #(
  parameter int DW = alu_pkg::DW,
  parameter int AW = alu_pkg::AW
);

  logic          dec_valid;
  logic          dec_ready;
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;
  logic [AW-1:0] dec_rd;
  logic [1:0]    dec_op;
  logic          dec_bi;

  logic          alu_valid;
  logic          alu_ready;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [1:0]    alu_op;
  logic          alu_bi;
  logic [AW-1:0] alu_rd;

  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  // slave is the issue stage itself; master is its environment
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_op, dec_bi,
    output dec_ready,
    output alu_valid, alu_in1, alu_in2, alu_op, alu_bi, alu_rd,
    input  alu_ready,
    input  wb_en, wb_addr, wb_data
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_op, dec_bi,
    input  dec_ready,
    input  alu_valid, alu_in1, alu_in2, alu_op, alu_bi, alu_rd,
    output alu_ready,
    output wb_en, wb_addr, wb_data
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file; register 0 is hard zero, reads bypass the
// concurrent write-back so new data is visible in the cycle it is written.
module regfile_2r1w
  import alu_pkg::*;
#(
  parameter int DW   = alu_pkg::DW,
  parameter int AW   = alu_pkg::AW,
  parameter int NREG = alu_pkg::NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      mem_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Zero check first so a write-back aimed at r0 never leaks through the bypass
  always_comb begin
    rd1_o = mem_q[rs1_i];
    if (rs1_i == '0)                         rd1_o = '0;
    else if (wb_en_i && (wb_addr_i == rs1_i)) rd1_o = wb_data_i;
  end

  always_comb begin
    rd2_o = mem_q[rs2_i];
    if (rs2_i == '0)                         rd2_o = '0;
    else if (wb_en_i && (wb_addr_i == rs2_i)) rd2_o = wb_data_i;
  end

endmodule

// File: rtl/regfile_issue.sv
// Operand-issue stage: register file read, pending-write scoreboard, hazard
// stall and a one-entry issue register handshaking with the ALU.
module regfile_issue
  import alu_pkg::*;
#(
  parameter int DW   = alu_pkg::DW,
  parameter int AW   = alu_pkg::AW,
  parameter int NREG = alu_pkg::NREG
) (
  input  logic            clk,
  input  logic            reset,
  regfile_issue_if.slave  bus
);

  logic [DW-1:0]   rd1, rd2;
  logic [NREG-1:0] pending_q, pending_d;
  iss_state_e      state_q, state_d;
  logic [DW-1:0]   in1_q, in2_q;
  logic [1:0]      op_q;
  logic            bi_q;
  logic [AW-1:0]   rd_q;
  logic            hazard, issue_free, accept;

  regfile_2r1w #(.DW(DW), .AW(AW), .NREG(NREG)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .rs1_i     (bus.dec_rs1),
    .rs2_i     (bus.dec_rs2),
    .wb_en_i   (bus.wb_en),
    .wb_addr_i (bus.wb_addr),
    .wb_data_i (bus.wb_data),
    .rd1_o     (rd1),
    .rd2_o     (rd2)
  );

  // A pending register stops being a hazard in the cycle its write-back arrives
  function automatic logic src_hz(input logic [NREG-1:0] pend, input logic [AW-1:0] r,
                                  input logic we, input logic [AW-1:0] wa);
    return pend[r] && !(we && (wa == r));
  endfunction

  always_comb begin
    hazard = src_hz(pending_q, bus.dec_rs1, bus.wb_en, bus.wb_addr)
           | src_hz(pending_q, bus.dec_rs2, bus.wb_en, bus.wb_addr)
           | src_hz(pending_q, bus.dec_rd,  bus.wb_en, bus.wb_addr);
  end

  assign issue_free    = (state_q == ISS_EMPTY) || bus.alu_ready;
  assign bus.dec_ready = issue_free && !hazard;
  assign accept        = bus.dec_valid && bus.dec_ready;

  // Clear before set so a same-edge write-back never hides a new claim
  always_comb begin
    pending_d = pending_q;
    if (bus.wb_en)                        pending_d[bus.wb_addr] = 1'b0;
    if (accept && (bus.dec_rd != '0))     pending_d[bus.dec_rd]  = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISS_EMPTY: if (accept) state_d = ISS_FULL;
      ISS_FULL:  if (bus.alu_ready && !accept) state_d = ISS_EMPTY;
      default:   state_d = ISS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ISS_EMPTY;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Operands are frozen at accept; later write-backs never touch them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in1_q <= '0;
      in2_q <= '0;
      op_q  <= '0;
      bi_q  <= 1'b0;
      rd_q  <= '0;
    end else if (accept) begin
      in1_q <= rd1;
      in2_q <= rd2;
      op_q  <= bus.dec_op;
      bi_q  <= bus.dec_bi;
      rd_q  <= bus.dec_rd;
    end
  end

  assign bus.alu_valid = (state_q == ISS_FULL);
  assign bus.alu_in1   = in1_q;
  assign bus.alu_in2   = in2_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_bi    = bi_q;
  assign bus.alu_rd    = rd_q;

endmodule
